// File: rtl/vscale_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_mem_arbiter
//   Shares one external memory port between the instruction-fetch requester
//   (imem) and the load/store requester (dmem). One transaction is in flight
//   at a time; a new grant may be issued in the same cycle the outstanding
//   response returns, so back-to-back traffic needs no bubble.
//
//   Build option:
//     VSCALE_ARB_ROUND_ROBIN_EN  when both requesters are eligible, grant the
//                                one that did not win last time. Undefined:
//                                fixed priority, dmem over imem.
//
//   Ports:
//     clk, reset_n                        clock, async active-low reset
//     imem_req/addr -> imem_wait/rdata/badmem_e    fetch side
//     dmem_en/wen/size/addr/wdata -> dmem_wait/rdata/badmem_e  data side
//     mem_req/wen/size/addr/wdata, mem_ready       memory request channel
//     mem_rvalid/rdata/badmem_e                     memory response channel
//     arb_err                             sticky: response seen while idle
// ---------------------------------------------------------------------------
module vscale_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imem_req,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_wait,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_badmem_e,
  input  logic                  dmem_en,
  input  logic                  dmem_wen,
  input  logic [2:0]            dmem_size,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_wait,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_badmem_e,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [2:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_badmem_e,
  output logic                  arb_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef struct packed {
    logic                  wen;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  localparam int         REQ_I      = 0;
  localparam int         REQ_D      = 1;
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  state_t         state, state_nxt;
  logic           last_grant_d, last_grant_d_nxt;  // 1: dmem won last grant
  logic           arb_err_nxt;
  logic [1:0]     req, done, elig, grant;
  logic           slot_open;
  mem_cmd_t [1:0] cmd;
  mem_cmd_t       cmd_sel;

  assign req = {dmem_en, imem_req};

  // per-requester command as it would appear on the memory port
  always_comb begin
    cmd              = '0;
    cmd[REQ_I].wen   = 1'b0;
    cmd[REQ_I].size  = FETCH_SIZE;
    cmd[REQ_I].addr  = imem_addr;
    cmd[REQ_I].wdata = '0;
    cmd[REQ_D].wen   = dmem_wen;
    cmd[REQ_D].size  = dmem_size;
    cmd[REQ_D].addr  = dmem_addr;
    cmd[REQ_D].wdata = dmem_wdata;
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      arb_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant_d <= last_grant_d_nxt;
      arb_err      <= arb_err_nxt;
    end
  end

  // next state, grant selection and command mux
  always_comb begin
    done             = '0;
    elig             = '0;
    grant            = '0;
    slot_open        = 1'b0;
    cmd_sel          = '0;
    state_nxt        = state;
    last_grant_d_nxt = last_grant_d;
    arb_err_nxt      = arb_err;

    done[REQ_I] = (state == BUSY_I) && mem_rvalid;
    done[REQ_D] = (state == BUSY_D) && mem_rvalid;
    slot_open   = (state == IDLE) || (|done);
    // the completing requester can only reissue from the following cycle
    elig        = req & ~done;

    // reset_n gates the grant so mem_req is low for the whole reset window
    if (slot_open && reset_n) begin
      if (&elig) begin
`ifdef VSCALE_ARB_ROUND_ROBIN_EN
        grant = last_grant_d ? 2'b01 : 2'b10;
`else
        grant = 2'b10;
`endif
      end else begin
        grant = elig;
      end
    end

    if (grant[REQ_D])      cmd_sel = cmd[REQ_D];
    else if (grant[REQ_I]) cmd_sel = cmd[REQ_I];

    if ((|grant) && mem_ready) begin
      state_nxt        = grant[REQ_D] ? BUSY_D : BUSY_I;
      last_grant_d_nxt = grant[REQ_D];
    end else if (|done) begin
      state_nxt = IDLE;
    end

    if ((state == IDLE) && mem_rvalid) arb_err_nxt = 1'b1;
  end

  assign mem_req   = |grant;
  assign mem_wen   = cmd_sel.wen;
  assign mem_size  = cmd_sel.size;
  assign mem_addr  = cmd_sel.addr;
  assign mem_wdata = cmd_sel.wdata;

  // response routing: only the completing requester sees data/error
  logic [1:0][DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                 rsp_err;

  for (genvar r = 0; r < 2; r++) begin : g_rsp
    assign rsp_rdata[r] = done[r] ? mem_rdata : '0;
    assign rsp_err[r]   = done[r] & mem_badmem_e;
  end

  assign imem_rdata    = rsp_rdata[REQ_I];
  assign imem_badmem_e = rsp_err[REQ_I];
  assign dmem_rdata    = rsp_rdata[REQ_D];
  assign dmem_badmem_e = rsp_err[REQ_D];

  assign imem_wait = imem_req & ~done[REQ_I];
  assign dmem_wait = dmem_en  & ~done[REQ_D];

  // last-grant always names the requester whose transaction is in flight
  assert property (@(posedge clk) disable iff (!reset_n)
                   (state != IDLE) |-> (last_grant_d == (state == BUSY_D)));

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
module tb_vscale_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef VSCALE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_wait;
  logic [DW-1:0] imem_rdata;
  logic          imem_badmem_e;
  logic          dmem_en, dmem_wen;
  logic [2:0]    dmem_size;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_wait;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_badmem_e;
  logic          mem_req, mem_wen;
  logic [2:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_badmem_e;
  logic          arb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vscale_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
    .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
    .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_badmem_e(mem_badmem_e), .arb_err(arb_err)
  );

  task automatic idle_inputs;
    imem_req = 0; imem_addr = '0;
    dmem_en = 0; dmem_wen = 0; dmem_size = '0; dmem_addr = '0; dmem_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_badmem_e = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); idle_inputs(); reset_n = 0;
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    idle_inputs(); reset_n = 0; imem_req = 1;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF; mem_badmem_e = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    checks++; if (imem_wait !== 1'b1) begin failures++; $display("FAIL rst_imem_wait got=%0h exp=1", imem_wait); end
    checks++; if (dmem_wait !== 1'b0) begin failures++; $display("FAIL rst_dmem_wait got=%0h exp=0", dmem_wait); end
    checks++; if (imem_rdata !== '0) begin failures++; $display("FAIL rst_imem_rdata got=%0h exp=0", imem_rdata); end
    checks++; if (imem_badmem_e !== 1'b0) begin failures++; $display("FAIL rst_imem_badmem got=%0h exp=0", imem_badmem_e); end
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL rst_arb_err got=%0h exp=0", arb_err); end
    @(negedge clk); idle_inputs(); reset_n = 1;
  endtask

  task automatic test_single_fetch;
    @(negedge clk); imem_req = 1; imem_addr = 32'h100; mem_ready = 1; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_addr got=%0h exp=100", mem_addr); end
    checks++; if (mem_size !== 3'b010) begin failures++; $display("FAIL fetch_size got=%0h exp=2", mem_size); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL fetch_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (imem_wait !== 1'b1) begin failures++; $display("FAIL fetch_wait0 got=%0h exp=1", imem_wait); end
    @(negedge clk); #1;
    checks++; if (imem_wait !== 1'b1) begin failures++; $display("FAIL fetch_wait1 got=%0h exp=1", imem_wait); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_busy_req got=%0h exp=0", mem_req); end
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
    checks++; if (imem_wait !== 1'b0) begin failures++; $display("FAIL fetch_wait2 got=%0h exp=0", imem_wait); end
    checks++; if (imem_rdata !== 32'h13) begin failures++; $display("FAIL fetch_rdata got=%0h exp=13", imem_rdata); end
    checks++; if (dmem_rdata !== '0) begin failures++; $display("FAIL fetch_dmem_rdata got=%0h exp=0", dmem_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_reissue got=%0h exp=0", mem_req); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (imem_rdata !== '0) begin failures++; $display("FAIL fetch_rdata_after got=%0h exp=0", imem_rdata); end
  endtask

  // both requesters hold their requests; each response frees the slot for
  // the other one, so grants alternate starting from the arbitration winner
  task automatic test_contention;
    bit g, prev_g;
    do_reset();
    g = RR ? 1'b0 : 1'b1;  // 0: imem, 1: dmem
    prev_g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_req = 1; imem_addr = 32'h300;
      dmem_en = 1; dmem_wen = 1; dmem_size = 3'b010; dmem_addr = 32'h200; dmem_wdata = 32'hDEAD_BEEF;
      mem_ready = 1; mem_rvalid = (k > 0); mem_rdata = 32'h1000 + k;
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL cont_req k=%0d got=%0h exp=1", k, mem_req); end
      checks++; if (mem_addr !== (g ? 32'h200 : 32'h300)) begin failures++; $display("FAIL cont_addr k=%0d got=%0h exp=%0h", k, mem_addr, g ? 32'h200 : 32'h300); end
      checks++; if (mem_wen !== g) begin failures++; $display("FAIL cont_wen k=%0d got=%0h exp=%0h", k, mem_wen, g); end
      if (g) begin
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cont_wdata k=%0d got=%0h exp=deadbeef", k, mem_wdata); end
      end
      checks++; if (imem_wait !== ((k == 0) || prev_g)) begin failures++; $display("FAIL cont_imem_wait k=%0d got=%0h exp=%0h", k, imem_wait, (k == 0) || prev_g); end
      checks++; if (dmem_wait !== ((k == 0) || !prev_g)) begin failures++; $display("FAIL cont_dmem_wait k=%0d got=%0h exp=%0h", k, dmem_wait, (k == 0) || !prev_g); end
      prev_g = g;
      g = ~g;
    end
    @(negedge clk); idle_inputs(); mem_rvalid = 1; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cont_drain got=%0h exp=0", mem_req); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'b000; dmem_addr = 32'h444; mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL bp_req k=%0d got=%0h exp=1", k, mem_req); end
      checks++; if (mem_addr !== 32'h444) begin failures++; $display("FAIL bp_addr k=%0d got=%0h exp=444", k, mem_addr); end
      checks++; if (mem_size !== 3'b000) begin failures++; $display("FAIL bp_size k=%0d got=%0h exp=0", k, mem_size); end
      checks++; if (dmem_wait !== 1'b1) begin failures++; $display("FAIL bp_wait k=%0d got=%0h exp=1", k, dmem_wait); end
    end
    @(negedge clk); mem_ready = 1; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL bp_grant got=%0h exp=1", mem_req); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_busy got=%0h exp=0", mem_req); end
    checks++; if (dmem_wait !== 1'b1) begin failures++; $display("FAIL bp_busy_wait got=%0h exp=1", dmem_wait); end
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; #1;
    checks++; if (dmem_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL bp_rdata got=%0h exp=cafe0001", dmem_rdata); end
    checks++; if (dmem_wait !== 1'b0) begin failures++; $display("FAIL bp_done_wait got=%0h exp=0", dmem_wait); end
    checks++; if (imem_rdata !== '0) begin failures++; $display("FAIL bp_imem_rdata got=%0h exp=0", imem_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_error;
    @(negedge clk); imem_req = 1; imem_addr = 32'h500; mem_ready = 1;
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD; mem_badmem_e = 1; #1;
    checks++; if (imem_badmem_e !== 1'b1) begin failures++; $display("FAIL err_imem_badmem got=%0h exp=1", imem_badmem_e); end
    checks++; if (dmem_badmem_e !== 1'b0) begin failures++; $display("FAIL err_dmem_badmem got=%0h exp=0", dmem_badmem_e); end
    checks++; if (imem_wait !== 1'b0) begin failures++; $display("FAIL err_wait got=%0h exp=0", imem_wait); end
    @(negedge clk); idle_inputs(); mem_badmem_e = 1; #1;
    checks++; if (imem_badmem_e !== 1'b0) begin failures++; $display("FAIL err_badmem_after got=%0h exp=0", imem_badmem_e); end
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL err_arb_pre got=%0h exp=0", arb_err); end
    @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h77; mem_badmem_e = 1; #1;
    checks++; if (imem_rdata !== '0) begin failures++; $display("FAIL stray_rdata got=%0h exp=0", imem_rdata); end
    checks++; if (dmem_badmem_e !== 1'b0) begin failures++; $display("FAIL stray_badmem got=%0h exp=0", dmem_badmem_e); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL stray_arb_err got=%0h exp=1", arb_err); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL arb_err_sticky got=%0h exp=1", arb_err); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); dmem_en = 1; dmem_addr = 32'h600; mem_ready = 1; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ar_issue got=%0h exp=1", mem_req); end
    @(negedge clk); imem_req = 1; imem_addr = 32'h700; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0h exp=0", mem_req); end
    #2 reset_n = 0; #1;
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL ar_arb_err got=%0h exp=0", arb_err); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ar_mem_req got=%0h exp=0", mem_req); end
    checks++; if (dmem_wait !== 1'b1) begin failures++; $display("FAIL ar_dmem_wait got=%0h exp=1", dmem_wait); end
    @(negedge clk); reset_n = 1; imem_req = 0; mem_ready = 0; #1;
    // a fresh issue is only visible if the arbiter really dropped to idle
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ar_idle_req got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h600) begin failures++; $display("FAIL ar_idle_addr got=%0h exp=600", mem_addr); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_kill;
    @(negedge clk); imem_req = 1; imem_addr = 32'h800; mem_ready = 1;
    @(negedge clk); imem_req = 0; dmem_en = 1; dmem_wen = 1; dmem_addr = 32'h900; dmem_wdata = 32'h55; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL kill_busy got=%0h exp=0", mem_req); end
    checks++; if (imem_wait !== 1'b0) begin failures++; $display("FAIL kill_imem_wait got=%0h exp=0", imem_wait); end
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h99; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL kill_regrant got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h900) begin failures++; $display("FAIL kill_addr got=%0h exp=900", mem_addr); end
    checks++; if (dmem_wait !== 1'b1) begin failures++; $display("FAIL kill_dmem_wait got=%0h exp=1", dmem_wait); end
    @(negedge clk); mem_rvalid = 0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL kill_busy_d got=%0h exp=0", mem_req); end
    @(negedge clk); mem_rvalid = 1; #1;
    checks++; if (dmem_wait !== 1'b0) begin failures++; $display("FAIL kill_dmem_done got=%0h exp=0", dmem_wait); end
    @(negedge clk); idle_inputs();
  endtask

  // random traffic vs. a transaction-level model: who owns the single
  // outstanding slot, who won last, and a memory that answers 1..3 cycles on
  task automatic test_random;
    int outst, last, g, done, cnt;
    bit ei, ed, open, e_iw, e_dw, prev_iw, prev_dw;
    do_reset();
    outst = 0; last = 2; cnt = 0; prev_iw = 0; prev_dw = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!prev_iw) begin
        imem_req = ($urandom_range(0, 2) != 0); imem_addr = $urandom & 32'hFFFC;
      end
      if (!prev_dw) begin
        dmem_en = ($urandom_range(0, 2) != 0); dmem_wen = $urandom_range(0, 1);
        dmem_size = $urandom_range(0, 5); dmem_addr = $urandom; dmem_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = (outst != 0) && (cnt == 0);
      mem_rdata = $urandom; mem_badmem_e = ($urandom_range(0, 7) == 0);
      #1;
      done = mem_rvalid ? outst : 0;
      ei = imem_req && (done != 1);
      ed = dmem_en && (done != 2);
      open = (outst == 0) || (done != 0);
      g = 0;
      if (open) begin
        if (ei && ed) g = RR ? ((last == 2) ? 1 : 2) : 2;
        else if (ed) g = 2;
        else if (ei) g = 1;
      end
      e_iw = ei; e_dw = ed;
      checks++; if (mem_req !== (g != 0)) begin failures++; $display("FAIL rnd_req c=%0d got=%0h exp=%0h", c, mem_req, g != 0); end
      if (g == 1) begin
        checks++; if (mem_addr !== imem_addr || mem_size !== 3'b010 || mem_wen !== 1'b0 || mem_wdata !== '0) begin failures++; $display("FAIL rnd_fetch_cmd c=%0d got=%0h/%0h/%0h exp=%0h/2/0", c, mem_addr, mem_size, mem_wen, imem_addr); end
      end else if (g == 2) begin
        checks++; if (mem_addr !== dmem_addr || mem_size !== dmem_size || mem_wen !== dmem_wen || mem_wdata !== dmem_wdata) begin failures++; $display("FAIL rnd_data_cmd c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, mem_addr, mem_size, mem_wen, dmem_addr, dmem_size, dmem_wen); end
      end
      checks++; if (imem_wait !== e_iw) begin failures++; $display("FAIL rnd_imem_wait c=%0d got=%0h exp=%0h", c, imem_wait, e_iw); end
      checks++; if (dmem_wait !== e_dw) begin failures++; $display("FAIL rnd_dmem_wait c=%0d got=%0h exp=%0h", c, dmem_wait, e_dw); end
      checks++; if (imem_rdata !== ((done == 1) ? mem_rdata : 32'h0) || imem_badmem_e !== ((done == 1) && mem_badmem_e)) begin failures++; $display("FAIL rnd_imem_rsp c=%0d got=%0h/%0h", c, imem_rdata, imem_badmem_e); end
      checks++; if (dmem_rdata !== ((done == 2) ? mem_rdata : 32'h0) || dmem_badmem_e !== ((done == 2) && mem_badmem_e)) begin failures++; $display("FAIL rnd_dmem_rsp c=%0d got=%0h/%0h", c, dmem_rdata, dmem_badmem_e); end
      checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL rnd_arb_err c=%0d got=%0h exp=0", c, arb_err); end
      prev_iw = e_iw; prev_dw = e_dw;
      if (g != 0 && mem_ready) begin
        outst = g; last = g; cnt = $urandom_range(0, 2);
      end else if (done != 0) begin
        outst = 0;
      end else if (outst != 0) begin
        cnt = cnt - 1;
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_error();
    test_async_reset();
    test_kill();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
